// File: rtl/scc_data_mem_responder.sv
// scc_data_mem_responder: wait-stated word RAM servicing the scc core's data read/write requests.
module scc_data_mem_responder #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2,
  parameter int AW      = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clk_en,
  input  logic        halt_f,
  input  logic        data_memory_read,
  input  logic        data_memory_write,
  input  logic [31:0] data_memory_a,
  input  logic [31:0] data_memory_out_v,
  output logic [31:0] data_memory_in_v,
  output logic        data_memory_ready,
  output logic        mem_busy,
  output logic [1:0]  err_bits
);
  typedef enum logic [1:0] {IDLE, WAIT, RESP, HALTED} state_t;
  state_t state, state_n;
  logic [3:0] cnt, cnt_n;
  logic [31:0] lat_a;
  logic lat_rd, halt_pend, one_req, go_resp, proto_err, addr_err, abort, halt_req;
  logic [AW-1:0] idx;
  logic [31:0] mem [DEPTH];
  assign one_req  = data_memory_read ^ data_memory_write;
  assign idx      = data_memory_a[AW+1:2];
  assign addr_err = (data_memory_a[1:0] != 2'b00) || ((data_memory_a >> (AW + 2)) != 32'd0);
  assign abort    = !one_req || data_memory_read != lat_rd || data_memory_a != lat_a;
  assign halt_req = halt_f || halt_pend;
  assign mem_busy = state == WAIT || state == RESP;
  // The access happens on the edge into RESP; the request is provably identical to the latched one there.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    go_resp   = 1'b0;
    proto_err = 1'b0;
    case (state)
      IDLE: begin
        if (halt_f) state_n = HALTED;
        else if (data_memory_read && data_memory_write) proto_err = 1'b1;
        else if (one_req) begin
          cnt_n   = 4'(LATENCY);
          go_resp = LATENCY == 0;
          state_n = LATENCY == 0 ? RESP : WAIT;
        end
      end
      WAIT: begin
        if (abort) begin
          proto_err = 1'b1;
          state_n   = halt_req ? HALTED : IDLE;
        end else begin
          cnt_n   = cnt - 4'd1;
          go_resp = cnt == 4'd1;
          state_n = cnt == 4'd1 ? RESP : WAIT;
        end
      end
      RESP:    state_n = halt_req ? HALTED : IDLE;
      default: state_n = HALTED;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= IDLE;
      cnt               <= 4'd0;
      lat_a             <= 32'd0;
      lat_rd            <= 1'b0;
      halt_pend         <= 1'b0;
      data_memory_in_v  <= 32'd0;
      data_memory_ready <= 1'b0;
      err_bits          <= 2'b00;
    end else if (clk_en) begin
      state             <= state_n;
      cnt               <= cnt_n;
      halt_pend         <= mem_busy && halt_req;
      data_memory_ready <= go_resp;
      err_bits          <= err_bits | {proto_err, go_resp && addr_err};
      if (state == IDLE) begin
        lat_a  <= data_memory_a;
        lat_rd <= data_memory_read;
      end
      if (go_resp && data_memory_read) data_memory_in_v <= addr_err ? 32'd0 : mem[idx];
    end
  end
  always_ff @(posedge clk)
    if (clk_en && go_resp && data_memory_write && !addr_err) mem[idx] <= data_memory_out_v;
endmodule

// File: tb/tb_scc_data_mem_responder.sv
// tb_scc_data_mem_responder: directed checks of the data-memory responder at LATENCY 2 and 0.
module tb_scc_data_mem_responder;
  logic clk = 1'b0, rst = 1'b0, clk_en = 1'b1, halt_f = 1'b0;
  logic rd = 1'b0, wr = 1'b0;
  logic [31:0] a = 32'd0, v = 32'd0;
  logic [31:0] in2, in0;
  logic rdy2, rdy0, busy2, busy0;
  logic [1:0] err2, err0;
  int pass = 0, total = 0;
  always #5 clk = ~clk;
  scc_data_mem_responder #(.DEPTH(256), .LATENCY(2)) dut (
    .clk(clk), .rst(rst), .clk_en(clk_en), .halt_f(halt_f),
    .data_memory_read(rd), .data_memory_write(wr), .data_memory_a(a), .data_memory_out_v(v),
    .data_memory_in_v(in2), .data_memory_ready(rdy2), .mem_busy(busy2), .err_bits(err2));
  scc_data_mem_responder #(.DEPTH(256), .LATENCY(0)) dut0 (
    .clk(clk), .rst(rst), .clk_en(clk_en), .halt_f(halt_f),
    .data_memory_read(rd), .data_memory_write(wr), .data_memory_a(a), .data_memory_out_v(v),
    .data_memory_in_v(in0), .data_memory_ready(rdy0), .mem_busy(busy0), .err_bits(err0));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask
  task automatic xfer(input logic r, input logic w, input logic [31:0] addr, input logic [31:0] val,
                      input bit z, output int cyc);
    rd = r;
    wr = w;
    a = addr;
    v = val;
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (!(z ? rdy0 : rdy2) && cyc < 20);
    rd = 1'b0;
    wr = 1'b0;
    tick();
  endtask
  initial begin
    int cyc, seen;
    reset();
    chk("rst_ready", 32'(rdy2), 32'd0);
    chk("rst_in_v", in2, 32'd0);
    chk("rst_busy", 32'(busy2), 32'd0);
    chk("rst_err", 32'(err2), 32'd0);
    xfer(1'b0, 1'b1, 32'h0, 32'h1234, 1'b1, cyc);
    chk("l0_wr_lat", cyc, 1);
    chk("l0_ready_pulse", 32'(rdy0), 32'd0);
    xfer(1'b1, 1'b0, 32'h0, 32'h0, 1'b1, cyc);
    chk("l0_rd_lat", cyc, 1);
    chk("l0_rd_data", in0, 32'h0000_1234);
    reset();
    xfer(1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0, cyc);
    chk("wr_lat", cyc, 3);
    chk("ready_pulse", 32'(rdy2), 32'd0);
    xfer(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, cyc);
    chk("rd_lat", cyc, 3);
    chk("rd_data", in2, 32'hDEAD_BEEF);
    chk("err_clean", 32'(err2), 32'd0);
    xfer(1'b1, 1'b0, 32'h13, 32'h0, 1'b0, cyc);
    chk("misalign_lat", cyc, 3);
    chk("misalign_data", in2, 32'd0);
    chk("misalign_err", 32'(err2), 32'd1);
    xfer(1'b0, 1'b1, 32'h400, 32'h5555_5555, 1'b0, cyc);
    xfer(1'b1, 1'b0, 32'h400, 32'h0, 1'b0, cyc);
    chk("range_lat", cyc, 3);
    chk("range_data", in2, 32'd0);
    chk("range_err", 32'(err2), 32'd1);
    xfer(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, cyc);
    chk("word10_kept", in2, 32'hDEAD_BEEF);
    reset();
    rd = 1'b1;
    wr = 1'b1;
    a = 32'h10;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      seen += int'(rdy2);
    end
    rd = 1'b0;
    wr = 1'b0;
    chk("both_no_ready", seen, 0);
    chk("both_err", 32'(err2), 32'd2);
    reset();
    rd = 1'b1;
    tick();
    chk("wait_busy", 32'(busy2), 32'd1);
    rd = 1'b0;
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      seen += int'(rdy2);
    end
    chk("abort_no_ready", seen, 0);
    chk("abort_err", 32'(err2), 32'd2);
    chk("abort_idle", 32'(busy2), 32'd0);
    reset();
    rd = 1'b1;
    a = 32'h10;
    tick();
    clk_en = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    chk("stall_busy", 32'(busy2), 32'd1);
    clk_en = 1'b1;
    cyc = 4;
    do begin
      tick();
      cyc++;
    end while (!rdy2 && cyc < 20);
    rd = 1'b0;
    chk("stall_lat", cyc, 6);
    chk("stall_data", in2, 32'hDEAD_BEEF);
    tick();
    wr = 1'b1;
    a = 32'h20;
    v = 32'hA5A5_A5A5;
    tick();
    halt_f = 1'b1;
    cyc = 1;
    do begin
      tick();
      cyc++;
    end while (!rdy2 && cyc < 20);
    wr = 1'b0;
    chk("halt_wr_lat", cyc, 3);
    tick();
    chk("halted_busy", 32'(busy2), 32'd0);
    rd = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      seen += int'(rdy2);
    end
    rd = 1'b0;
    chk("halted_no_ready", seen, 0);
    chk("halted_in_v_hold", in2, 32'hDEAD_BEEF);
    halt_f = 1'b0;
    reset();
    chk("rst2_in_v", in2, 32'd0);
    chk("rst2_ready", 32'(rdy2), 32'd0);
    chk("rst2_err", 32'(err2), 32'd0);
    xfer(1'b1, 1'b0, 32'h20, 32'h0, 1'b0, cyc);
    chk("post_halt_lat", cyc, 3);
    chk("post_halt_data", in2, 32'hA5A5_A5A5);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
